// File: rtl/cfg_csh_bar_regs.sv
// cfg_csh_bar_regs: config-space BAR0/1/2 and expansion ROM BAR registers with pulse/ack access
module cfg_csh_bar_regs #(
    parameter logic [11:0] ROM_ADDR      = 12'h030,
    parameter logic [11:0] BAR_BASE_ADDR = 12'h010
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cfg_wr_valid,
    input  logic        cfg_rd_valid,
    input  logic [11:0] cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic [3:0]  cfg_be,
    output logic        cfg_ack,
    output logic [31:0] cfg_rdata,
    output logic        cfg_hit,
    output logic        cfg_overrun,
    input  logic [63:0] ro_bar0_size,
    input  logic [63:0] ro_bar1_size,
    input  logic [63:0] ro_bar2_size,
    input  logic        ro_bar0_pref,
    input  logic        ro_bar1_pref,
    input  logic        ro_bar2_pref,
    input  logic [31:0] ro_rom_bar,
    output logic [63:0] bar0_base,
    output logic [63:0] bar1_base,
    output logic [63:0] bar2_base,
    output logic [31:0] rom_base
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nxt;
    logic [9:0]  dw_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        wr_q;
    logic [31:0] lo_q [3];
    logic [31:0] hi_q [3];
    logic [31:0] rom_q;
    logic [63:0] size [3];
    logic        pref [3];
    logic        impl [3];
    logic [31:0] lo_mask [3];
    logic [31:0] hi_mask [3];
    logic [31:0] lo_rd [4];
    logic [31:0] hi_rd [4];
    logic [9:0]  off;
    logic [1:0]  bar_sel;
    logic        bar_hit, rom_hit, req;
    logic [31:0] rom_mask, rom_rd, rd_val;
    logic        unused;
    assign unused  = ^cfg_addr[1:0];
    assign req     = cfg_wr_valid | cfg_rd_valid;
    assign size[0] = ro_bar0_size;
    assign size[1] = ro_bar1_size;
    assign size[2] = ro_bar2_size;
    assign pref[0] = ro_bar0_pref;
    assign pref[1] = ro_bar1_pref;
    assign pref[2] = ro_bar2_pref;
    // Address decode, per-BAR masks and readback values (mask applied live on every read)
    always_comb begin
        off      = dw_q - BAR_BASE_ADDR[11:2];
        bar_hit  = off < 10'd6;
        bar_sel  = off[2:1];
        rom_hit  = dw_q == ROM_ADDR[11:2];
        lo_rd[3] = '0;
        hi_rd[3] = '0;
        for (int i = 0; i < 3; i++) begin
            impl[i]    = size[i] != '1;
            lo_mask[i] = impl[i] ? {size[i][31:4], 4'b0} : '0;
            hi_mask[i] = impl[i] ? size[i][63:32] : '0;
            lo_rd[i]   = impl[i] ? (lo_q[i] & lo_mask[i]) | {28'b0, pref[i], 3'b100} : '0;
            hi_rd[i]   = hi_q[i] & hi_mask[i];
        end
        rom_mask = ro_rom_bar != '0 ? {ro_rom_bar[31:11], 10'b0, 1'b1} : '0;
        rom_rd   = rom_q & rom_mask;
        rd_val   = bar_hit ? (off[0] ? hi_rd[bar_sel] : lo_rd[bar_sel]) : rom_hit ? rom_rd : '0;
    end
    assign bar0_base = {hi_rd[0], lo_rd[0][31:4], 4'b0};
    assign bar1_base = {hi_rd[1], lo_rd[1][31:4], 4'b0};
    assign bar2_base = {hi_rd[2], lo_rd[2][31:4], 4'b0};
    assign rom_base  = rom_rd;
    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    // Next state: one cycle to execute, one cycle to respond
    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (req ? EXEC : IDLE) : state == EXEC ? RESP : IDLE;
    end
    // Request capture, response registers and sticky overrun flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dw_q        <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            wr_q        <= 1'b0;
            cfg_ack     <= 1'b0;
            cfg_rdata   <= '0;
            cfg_hit     <= 1'b0;
            cfg_overrun <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                dw_q    <= cfg_addr[11:2];
                wdata_q <= cfg_wdata;
                be_q    <= cfg_be;
                wr_q    <= cfg_wr_valid;
            end
            cfg_ack   <= state == EXEC;
            cfg_rdata <= (state == EXEC && !wr_q) ? rd_val : '0;
            cfg_hit   <= state == EXEC && (bar_hit || rom_hit);
            if ((req && state != IDLE) || (cfg_wr_valid && cfg_rd_valid)) cfg_overrun <= 1'b1;
        end
    end
    // Byte-enabled register writes; unimplemented BARs and a zero ROM mask drop writes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                lo_q[i] <= '0;
                hi_q[i] <= '0;
            end
            rom_q <= '0;
        end else if (state == EXEC && wr_q) begin
            for (int i = 0; i < 3; i++)
                for (int k = 0; k < 4; k++)
                    if (bar_hit && bar_sel == 2'(i) && impl[i] && be_q[k]) begin
                        if (off[0]) hi_q[i][8*k+:8] <= wdata_q[8*k+:8] & hi_mask[i][8*k+:8];
                        else lo_q[i][8*k+:8] <= wdata_q[8*k+:8] & lo_mask[i][8*k+:8];
                    end
            for (int k = 0; k < 4; k++)
                if (rom_hit && rom_mask != '0 && be_q[k]) rom_q[8*k+:8] <= wdata_q[8*k+:8] & rom_mask[8*k+:8];
        end
    end
endmodule
